// File: rtl/divisor_sequencer.sv
// divisor_sequencer: counter-based clock divider driven by a small run-time
// table. Each table entry gives a half-period overflow value and a period
// repetition count; an IDLE/RUN FSM walks entries 0..Len once or forever.
module divisor_sequencer #(
  parameter int STEPS = 4
) (
  input  logic        Clk_in,
  input  logic        Rst,
  input  logic        Wr_en,
  input  logic [1:0]  Wr_addr,
  input  logic [32:0] Wr_ovf,
  input  logic [7:0]  Wr_reps,
  input  logic [1:0]  Len,
  input  logic        Loop,
  input  logic        Start,
  input  logic        Stop,
  output logic        Clk_out,
  output logic        Tick,
  output logic        Busy,
  output logic [1:0]  Step,
  output logic        Done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_reg, state_next;

  // Step table. Kept in flops rather than RAM because reset must clear it
  // and the active entry is read combinationally in the same cycle.
  logic [32:0] tbl_ovf_reg  [STEPS];
  logic [7:0]  tbl_reps_reg [STEPS];

  // Divider and sequencing state.
  logic [32:0] cnt_reg, cnt_next;
  logic        tog_reg, tog_next;      // 0: next toggle rises, 1: next toggle falls
  logic [7:0]  rep_reg, rep_next;      // completed periods within current step
  logic [1:0]  step_reg, step_next;
  logic [1:0]  len_reg, len_next;
  logic        loop_reg, loop_next;
  logic        clk_out_reg, clk_out_next;
  logic        tick_reg, tick_next;
  logic        done_reg, done_next;

  // Active-step parameters and the divider comparison (34 bits so that
  // doubling the 33-bit count can never wrap).
  logic [32:0] cur_ovf;
  logic [7:0]  cur_reps;
  logic [33:0] cnt_x2;
  logic [33:0] ovf_ext;
  logic        cnt_below;
  logic        last_toggle_of_step;
  logic        last_step;
  logic        tbl_wr_ok;

  assign cur_ovf   = tbl_ovf_reg[step_reg];
  assign cur_reps  = tbl_reps_reg[step_reg];
  assign cnt_x2    = {cnt_reg, 1'b0};
  assign ovf_ext   = {1'b0, cur_ovf};
  assign cnt_below = (cnt_x2 < ovf_ext);

  // A step finishes on the falling toggle of its last period.
  assign last_toggle_of_step = tog_reg && (rep_reg == cur_reps);
  assign last_step           = (step_reg == len_reg);

  // The table is frozen for the whole run so a step never sees a mid-run edit.
  assign tbl_wr_ok = Wr_en && (state_reg == IDLE);

  // One write port per table entry, selected by address decode.
  generate
    for (genvar gi = 0; gi < STEPS; gi++) begin : g_tbl
      // Table entry gi: cleared by reset, written only while idle.
      always_ff @(posedge Clk_in or posedge Rst) begin
        if (Rst) begin
          tbl_ovf_reg[gi]  <= '0;
          tbl_reps_reg[gi] <= '0;
        end else if (tbl_wr_ok && (Wr_addr == 2'(gi))) begin
          tbl_ovf_reg[gi]  <= Wr_ovf;
          tbl_reps_reg[gi] <= Wr_reps;
        end
      end
    end
  endgenerate

  // State and datapath registers; all outputs come straight from flops.
  always_ff @(posedge Clk_in or posedge Rst) begin
    if (Rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      tog_reg     <= 1'b0;
      rep_reg     <= '0;
      step_reg    <= '0;
      len_reg     <= '0;
      loop_reg    <= 1'b0;
      clk_out_reg <= 1'b0;
      tick_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      tog_reg     <= tog_next;
      rep_reg     <= rep_next;
      step_reg    <= step_next;
      len_reg     <= len_next;
      loop_reg    <= loop_next;
      clk_out_reg <= clk_out_next;
      tick_reg    <= tick_next;
      done_reg    <= done_next;
    end
  end

  // Next-state, divider and step sequencing.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    tog_next     = tog_reg;
    rep_next     = rep_reg;
    step_next    = step_reg;
    len_next     = len_reg;
    loop_next    = loop_reg;
    clk_out_next = clk_out_reg;
    tick_next    = 1'b0;
    done_next    = 1'b0;

    unique case (state_reg)
      IDLE: begin
        // Stop beats a simultaneous Start.
        if (Start && !Stop) begin
          state_next   = RUN;
          cnt_next     = '0;
          tog_next     = 1'b0;
          rep_next     = '0;
          step_next    = '0;
          len_next     = Len;
          loop_next    = Loop;
          clk_out_next = 1'b0;
        end
      end

      RUN: begin
        if (Stop) begin
          // Abort: force the output low, announcing it only if it moves.
          state_next   = IDLE;
          cnt_next     = '0;
          tog_next     = 1'b0;
          rep_next     = '0;
          step_next    = '0;
          clk_out_next = 1'b0;
          tick_next    = clk_out_reg;
        end else if (cnt_below) begin
          cnt_next = cnt_reg + 33'd1;
        end else begin
          cnt_next     = '0;
          clk_out_next = ~clk_out_reg;
          tick_next    = 1'b1;
          if (!tog_reg) begin
            tog_next = 1'b1;
          end else if (!last_toggle_of_step) begin
            tog_next = 1'b0;
            rep_next = rep_reg + 8'd1;
          end else begin
            tog_next = 1'b0;
            rep_next = '0;
            if (!last_step) begin
              step_next = step_reg + 2'd1;
            end else if (loop_reg) begin
              step_next = '0;
            end else begin
              state_next = IDLE;
              step_next  = '0;
              done_next  = 1'b1;
            end
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign Clk_out = clk_out_reg;
  assign Tick    = tick_reg;
  assign Busy    = (state_reg == RUN);
  assign Step    = step_reg;
  assign Done    = done_reg;

endmodule

// File: tb/tb_divisor_sequencer.sv
// Directed bench for divisor_sequencer: cycle-by-cycle trace tables for the
// minimum and two-step runs, plus hand-written loop, stop, reset and
// protection sequences. Inputs change and outputs are sampled on negedges.
module tb_divisor_sequencer;

  logic        Clk_in = 1'b0;
  logic        Rst = 1'b1;
  logic        Wr_en = 1'b0;
  logic [1:0]  Wr_addr = '0;
  logic [32:0] Wr_ovf = '0;
  logic [7:0]  Wr_reps = '0;
  logic [1:0]  Len = '0;
  logic        Loop = 1'b0;
  logic        Start = 1'b0;
  logic        Stop = 1'b0;
  logic        Clk_out, Tick, Busy, Done;
  logic [1:0]  Step;

  divisor_sequencer #(.STEPS(4)) dut (
    .Clk_in (Clk_in),
    .Rst    (Rst),
    .Wr_en  (Wr_en),
    .Wr_addr(Wr_addr),
    .Wr_ovf (Wr_ovf),
    .Wr_reps(Wr_reps),
    .Len    (Len),
    .Loop   (Loop),
    .Start  (Start),
    .Stop   (Stop),
    .Clk_out(Clk_out),
    .Tick   (Tick),
    .Busy   (Busy),
    .Step   (Step),
    .Done   (Done)
  );

  always #5 Clk_in = ~Clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  // exp bit order: {Clk_out, Tick, Busy, Step[1:0], Done}
  typedef struct {
    logic       start;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[24];

  function automatic logic [5:0] obs();
    return {Clk_out, Tick, Busy, Step, Done};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns one negedge later with the write landed.
  task automatic write_entry(input logic [1:0] a, input logic [32:0] o, input logic [7:0] r);
    Wr_en = 1'b1; Wr_addr = a; Wr_ovf = o; Wr_reps = r;
    @(negedge Clk_in);
    Wr_en = 1'b0;
  endtask

  // Entry lo is cycle 0 of the run (its start bit is driven in that cycle).
  task automatic apply_vecs(input int lo, input int hi, input string tag);
    for (int i = lo; i <= hi; i++) begin
      check($sformatf("%s_cyc%0d", tag, i - lo), 64'(obs()), 64'(vecs[i].exp));
      Start = vecs[i].start;
      @(negedge Clk_in);
    end
    Start = 1'b0;
    $display("[TB] %s trace applied (%0d cycles)", tag, hi - lo + 1);
  endtask

  // Pulse Start in cycle 0, return the cycle Done is seen (-1 on timeout).
  task automatic run_len(input logic [1:0] l, input logic lp, output int dc);
    Len = l; Loop = lp; Start = 1'b1;
    @(negedge Clk_in);
    Start = 1'b0;
    dc = -1;
    for (int c = 1; c <= 200; c++) begin
      if (Done) begin
        dc = c;
        break;
      end
      @(negedge Clk_in);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    int togs;
    int pos;
    logic [5:0] e;

    // Minimum run: ovf=0 reps=0, Len=0.
    vecs[0] = '{1'b1, 6'b000000};
    vecs[1] = '{1'b0, 6'b001000};
    vecs[2] = '{1'b0, 6'b111000};
    vecs[3] = '{1'b0, 6'b010001};
    vecs[4] = '{1'b0, 6'b000000};
    // Two-step run: entry0 ovf=2 reps=0, entry1 ovf=4 reps=1, Len=1.
    vecs[5]  = '{1'b1, 6'b000000};
    vecs[6]  = '{1'b0, 6'b001000};
    vecs[7]  = '{1'b0, 6'b001000};
    vecs[8]  = '{1'b0, 6'b111000};
    vecs[9]  = '{1'b0, 6'b101000};
    vecs[10] = '{1'b0, 6'b011010};
    vecs[11] = '{1'b0, 6'b001010};
    vecs[12] = '{1'b0, 6'b001010};
    vecs[13] = '{1'b0, 6'b111010};
    vecs[14] = '{1'b0, 6'b101010};
    vecs[15] = '{1'b0, 6'b101010};
    vecs[16] = '{1'b0, 6'b011010};
    vecs[17] = '{1'b0, 6'b001010};
    vecs[18] = '{1'b0, 6'b001010};
    vecs[19] = '{1'b0, 6'b111010};
    vecs[20] = '{1'b0, 6'b101010};
    vecs[21] = '{1'b0, 6'b101010};
    vecs[22] = '{1'b0, 6'b010001};
    vecs[23] = '{1'b0, 6'b000000};

    // Reset state.
    repeat (2) @(negedge Clk_in);
    check("reset_outputs", 64'(obs()), 64'd0);
    Rst = 1'b0;
    @(negedge Clk_in);
    check("post_reset_outputs", 64'(obs()), 64'd0);

    // Minimum run.
    write_entry(2'd0, 33'd0, 8'd0);
    Len = 2'd0; Loop = 1'b0;
    apply_vecs(0, 4, "min_run");

    // Two-step run.
    write_entry(2'd0, 33'd2, 8'd0);
    write_entry(2'd1, 33'd4, 8'd1);
    Len = 2'd1; Loop = 1'b0;
    apply_vecs(5, 23, "two_step");

    // Loop mode: three iterations of the 16-cycle pattern, then Stop high.
    Len = 2'd1; Loop = 1'b1; Start = 1'b1;
    @(negedge Clk_in);
    Start = 1'b0; Loop = 1'b0;
    for (int c = 1; c <= 51; c++) begin
      pos = ((c - 1) % 16) + 1;
      e = vecs[5 + pos].exp;
      if (pos == 1 && c > 1) e[4] = 1'b1;  // falling edge closing previous iteration
      check($sformatf("loop_cyc%0d", c), 64'(obs()), 64'(e));
      if (c == 17) check("loop_step_wrap", 64'(Step), 64'd0);
      if (c == 51) Stop = 1'b1;
      @(negedge Clk_in);
    end
    Stop = 1'b0;
    check("loop_stop", 64'(obs()), 64'(6'b010000));
    $display("[TB] loop run stopped after 51 cycles");
    @(negedge Clk_in);

    // Large overflow: no toggle in 1000 cycles, then asynchronous reset.
    write_entry(2'd0, 33'h1_FFFF_FFFF, 8'd0);
    Len = 2'd0; Loop = 1'b0; Start = 1'b1;
    @(negedge Clk_in);
    Start = 1'b0;
    togs = 0;
    for (int c = 0; c < 1000; c++) begin
      if (Tick || Clk_out) togs++;
      @(negedge Clk_in);
    end
    check("big_ovf_toggles", 64'(togs), 64'd0);
    check("big_ovf_busy", 64'(Busy), 64'd1);
    @(posedge Clk_in);
    #2 Rst = 1'b1;
    #1 check("async_reset_outputs", 64'(obs()), 64'd0);
    @(negedge Clk_in);
    Rst = 1'b0;
    @(negedge Clk_in);
    run_len(2'd0, 1'b0, dc);   // cleared entry0 => minimum run length
    check("table_cleared_done_cyc", 64'(dc), 64'd3);
    $display("[TB] large overflow + async reset done, post-reset run done at %0d", dc);

    // Write and Start while busy are both ignored.
    write_entry(2'd0, 33'd2, 8'd0);
    Len = 2'd0; Loop = 1'b0; Start = 1'b1;
    @(negedge Clk_in);                        // cycle 1
    Start = 1'b0;
    @(negedge Clk_in);                        // cycle 2
    Wr_en = 1'b1; Wr_addr = 2'd0; Wr_ovf = 33'd0; Wr_reps = 8'd5;
    @(negedge Clk_in);                        // cycle 3
    Wr_en = 1'b0; Start = 1'b1;
    @(negedge Clk_in);                        // cycle 4
    Start = 1'b0;
    @(negedge Clk_in);                        // cycle 5
    check("busy_run_done", 64'(Done), 64'd1);
    @(negedge Clk_in);                        // cycle 6
    check("busy_start_ignored", 64'(Busy), 64'd0);
    run_len(2'd0, 1'b0, dc);
    check("table_protected_done_cyc", 64'(dc), 64'd5);
    // Back-to-back: Start in the Done cycle.
    run_len(2'd0, 1'b0, dc);
    check("start_on_done_cyc", 64'(dc), 64'd5);
    $display("[TB] protection runs complete, last done at %0d", dc);

    // Start with Stop while idle.
    @(negedge Clk_in);
    Start = 1'b1; Stop = 1'b1;
    @(negedge Clk_in);
    Start = 1'b0; Stop = 1'b0;
    check("start_stop_idle_busy", 64'(Busy), 64'd0);
    @(negedge Clk_in);
    check("start_stop_idle_busy2", 64'(Busy), 64'd0);

    // Write together with Start: new value used by the run.
    Wr_en = 1'b1; Wr_addr = 2'd0; Wr_ovf = 33'd0; Wr_reps = 8'd0;
    Len = 2'd0; Loop = 1'b0; Start = 1'b1;
    @(negedge Clk_in);
    Wr_en = 1'b0; Start = 1'b0;
    dc = -1;
    for (int c = 1; c <= 50; c++) begin
      if (Done) begin
        dc = c;
        break;
      end
      @(negedge Clk_in);
    end
    check("write_with_start_done_cyc", 64'(dc), 64'd3);
    $display("[TB] write+start run done at %0d", dc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
